button_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the multiplier control FSM.
- Takes the raw active-low pushbuttons (Run, ClearA_LoadB) and the raw slide switches (the B/S operand), then synchronizes, debounces and registers them.
- Outputs are clean levels plus one-cycle press pulses. The control FSM relies on these levels: it leaves HOLD only when Run drops, and leaves CLRA_LDB only when ClearA_LoadB drops, so the levels must be glitch-free.

---
 rtl/button_conditioner_if.sv | 42 ++++
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//
// Bundles the raw pushbutton/switch inputs and the conditioned outputs of
// button_conditioner.
//
//   master : the board side. Drives the raw keys/switches and observes the
//            clean levels and pulses.
//   slave  : the conditioner itself.
//
// Signals
//   Run_n_raw            raw Run key, active-low, asynchronous
//   ClearA_LoadB_n_raw   raw ClearA_LoadB key, active-low, asynchronous
//   SW_raw               raw slide switches, asynchronous
//   Run                  debounced Run level, active-high
//   ClearA_LoadB         debounced ClearA_LoadB level, active-high
//   Run_pulse            one-cycle strobe on Run 0->1
//   ClearA_LoadB_pulse   one-cycle strobe on ClearA_LoadB 0->1
//   SW                   synchronized switch value
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int SW_W = 8
);
  logic            Run_n_raw;
  logic            ClearA_LoadB_n_raw;
  logic [SW_W-1:0] SW_raw;
  logic            Run;
  logic            ClearA_LoadB;
  logic            Run_pulse;
  logic            ClearA_LoadB_pulse;
  logic [SW_W-1:0] SW;

  modport master (
    output Run_n_raw, ClearA_LoadB_n_raw, SW_raw,
    input  Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW
  );

  modport slave (
    input  Run_n_raw, ClearA_LoadB_n_raw, SW_raw,
    output Run, ClearA_LoadB, Run_pulse, ClearA_LoadB_pulse, SW
  );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Input conditioning in front of the multiplier control FSM. The two
// active-low keys are brought into the Clk domain with 2-flop synchronizers
// and then debounced: a channel's level only changes after DB_LIMIT
// consecutive cycles disagreeing with it, and any single agreeing cycle
// restarts the count. A registered pulse marks the cycle a level first
// reads 1. The switches are only synchronized (2-cycle latency).
//
// Parameters
//   DB_LIMIT  consecutive stable cycles needed to accept a key change
//             (2 .. 2**DB_CNT_W-1)
//   DB_CNT_W  debounce counter width
//   SW_W      switch bus width
//
// Ports
//   Clk    system clock, all state changes on posedge
//   Reset  synchronous active-high reset
//   bus    button_conditioner_if.slave (raw inputs, clean outputs)
//
// Build option
//   BTN_INTERLOCK_EN  when defined, ClearA_LoadB cannot rise while Run is
//                     high (its counter is held at 0 while its level is 0),
//                     so no operand load can be requested mid-multiply.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_CNT_W = 16,
  parameter int SW_W     = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  button_conditioner_if.slave  bus
);

  // Channel index 0 = Run, 1 = ClearA_LoadB.
  localparam int                NK       = 2;
  localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DB_LIMIT - 1);

  logic [NK-1:0]       key_s1;
  logic [NK-1:0]       key_s2;
  logic [SW_W-1:0]     sw_s1;
  logic [SW_W-1:0]     sw_s2;

  logic [NK-1:0]       level;
  logic [NK-1:0]       pulse;
  logic [DB_CNT_W-1:0] cnt       [NK];

  logic [NK-1:0]       level_nxt;
  logic [NK-1:0]       pulse_nxt;
  logic [DB_CNT_W-1:0] cnt_nxt   [NK];
  logic [NK-1:0]       hold;

  // Interlock: while Run is high, a low ClearA_LoadB level is frozen.
  // A ClearA_LoadB level that is already high is left alone so it can
  // release normally.
  always_comb begin
    hold = '0;
`ifdef BTN_INTERLOCK_EN
    hold[1] = level[0] & ~level[1];
`else
    hold[1] = 1'b0;
`endif
  end

  // Debounce next-state for both channels.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    level_nxt = level;
    pulse_nxt = '0;
    cnt_nxt   = cnt;
    for (int i = 0; i < NK; i++) begin
      if (hold[i] || (~key_s2[i] == level[i])) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == LIMIT_M1) begin
        // DB_LIMIT-th consecutive mismatch: accept the new level. The pulse
        // is registered alongside so it is high exactly when level first
        // reads 1, and never on release.
        level_nxt[i] = ~key_s2[i];
        pulse_nxt[i] = ~key_s2[i];
        cnt_nxt[i]   = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer
    // stages into a single flop.
    if (Reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
      level  <= '0;
      pulse  <= '0;
      // NOTE: the counter array is reset explicitly; a reset in the middle
      // of a debounce must discard the partial count.
      for (int i = 0; i < NK; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_s1 <= {bus.ClearA_LoadB_n_raw, bus.Run_n_raw};
      key_s2 <= key_s1;
      sw_s1  <= bus.SW_raw;
      sw_s2  <= sw_s1;
      level  <= level_nxt;
      pulse  <= pulse_nxt;
      for (int i = 0; i < NK; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.Run                = level[0];
  assign bus.ClearA_LoadB       = level[1];
  assign bus.Run_pulse          = pulse[0];
  assign bus.ClearA_LoadB_pulse = pulse[1];
  assign bus.SW                 = sw_s2;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DB_LIMIT = 4. Inputs change
// 1 ns after a rising edge and outputs are sampled at the same point, so a
// value read after tick i reflects rising edge e0+i, where e0 is the edge
// just before the stimulus was applied. A clean key edge applied there
// makes the level change after tick DB_LIMIT+2 = 6.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int SW_W     = 8;
  localparam int DB_LIMIT = 4;
  localparam int RISE     = DB_LIMIT + 2;

  logic Clk = 1'b0;
  logic Reset;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  button_conditioner_if #(.SW_W(SW_W)) bus ();

  button_conditioner #(
    .DB_LIMIT(DB_LIMIT),
    .DB_CNT_W(16),
    .SW_W    (SW_W)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    Reset                  = 1'b1;
    bus.Run_n_raw          = 1'b1;
    bus.ClearA_LoadB_n_raw = 1'b1;
    bus.SW_raw             = 8'h00;
    tick();
    checks++;
    if ({bus.Run, bus.ClearA_LoadB, bus.Run_pulse, bus.ClearA_LoadB_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_levels got %b%b%b%b exp 0000", bus.Run, bus.ClearA_LoadB,
               bus.Run_pulse, bus.ClearA_LoadB_pulse);
    end
    checks++;
    if (bus.SW !== 8'h00) begin
      errors++;
      $display("FAIL reset_sw got %h exp 00", bus.SW);
    end
    tick();
    Reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus.Run, bus.Run_pulse, bus.ClearA_LoadB, bus.ClearA_LoadB_pulse} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_released i=%0d got %b%b%b%b exp 0000", i, bus.Run, bus.Run_pulse,
                 bus.ClearA_LoadB, bus.ClearA_LoadB_pulse);
      end
    end
  endtask

  task automatic test_press_release();
    bus.Run_n_raw = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.Run, bus.Run_pulse} !== {1'(i >= RISE), 1'(i == RISE)}) begin
        errors++;
        $display("FAIL run_press i=%0d got L=%b P=%b exp L=%b P=%b", i, bus.Run,
                 bus.Run_pulse, i >= RISE, i == RISE);
      end
      checks++;
      if (bus.ClearA_LoadB !== 1'b0) begin
        errors++;
        $display("FAIL run_press_other i=%0d got %b exp 0", i, bus.ClearA_LoadB);
      end
    end
    bus.Run_n_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.Run, bus.Run_pulse} !== {1'(i < RISE), 1'b0}) begin
        errors++;
        $display("FAIL run_release i=%0d got L=%b P=%b exp L=%b P=0", i, bus.Run,
                 bus.Run_pulse, i < RISE);
      end
    end
  endtask

  // Raw pattern 0,0,0,1,0,0,0,0 applied before edges k..k+7 (k = e0+1).
  // Mismatches counted at k+2..k+4, reset at k+5, then k+6..k+9 -> rise
  // at k+9, i.e. after tick 10.
  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b0000_1000;  // bit j is the raw value before edge k+j
    bus.Run_n_raw = pat[0];
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i < 8) bus.Run_n_raw = pat[i];
      checks++;
      if ({bus.Run, bus.Run_pulse} !== {1'(i >= 10), 1'(i == 10)}) begin
        errors++;
        $display("FAIL bounce i=%0d got L=%b P=%b exp L=%b P=%b", i, bus.Run,
                 bus.Run_pulse, i >= 10, i == 10);
      end
    end
    bus.Run_n_raw = 1'b1;
    idle(8);
    checks++;
    if (bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL bounce_release got %b exp 0", bus.Run);
    end
  endtask

  task automatic test_both_keys();
    bus.Run_n_raw          = 1'b0;
    bus.ClearA_LoadB_n_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({bus.Run, bus.ClearA_LoadB, bus.Run_pulse, bus.ClearA_LoadB_pulse} !==
          {1'(i >= RISE), 1'(i >= RISE), 1'(i == RISE), 1'(i == RISE)}) begin
        errors++;
        $display("FAIL both_keys i=%0d got %b%b%b%b exp L=%b P=%b", i, bus.Run,
                 bus.ClearA_LoadB, bus.Run_pulse, bus.ClearA_LoadB_pulse, i >= RISE, i == RISE);
      end
    end
    bus.Run_n_raw          = 1'b1;
    bus.ClearA_LoadB_n_raw = 1'b1;
    idle(8);
    checks++;
    if ({bus.Run, bus.ClearA_LoadB} !== 2'b00) begin
      errors++;
      $display("FAIL both_release got %b%b exp 00", bus.Run, bus.ClearA_LoadB);
    end
  endtask

  // ClearA_LoadB pressed while Run is already high.
  task automatic test_clear_during_run();
    bus.Run_n_raw = 1'b0;
    idle(RISE);
    checks++;
    if (bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL run_up got %b exp 1", bus.Run);
    end
    bus.ClearA_LoadB_n_raw = 1'b0;
`ifdef BTN_INTERLOCK_EN
    for (int i = 1; i <= 50; i++) begin
      tick();
      checks++;
      if ({bus.ClearA_LoadB, bus.ClearA_LoadB_pulse, bus.Run} !== 3'b001) begin
        errors++;
        $display("FAIL interlock i=%0d got C=%b CP=%b R=%b exp C=0 CP=0 R=1", i,
                 bus.ClearA_LoadB, bus.ClearA_LoadB_pulse, bus.Run);
      end
    end
`else
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({bus.ClearA_LoadB, bus.ClearA_LoadB_pulse, bus.Run, bus.Run_pulse} !==
          {1'(i >= RISE), 1'(i == RISE), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL independent i=%0d got C=%b CP=%b R=%b RP=%b exp C=%b CP=%b R=1 RP=0", i,
                 bus.ClearA_LoadB, bus.ClearA_LoadB_pulse, bus.Run, bus.Run_pulse,
                 i >= RISE, i == RISE);
      end
    end
`endif
    bus.Run_n_raw          = 1'b1;
    bus.ClearA_LoadB_n_raw = 1'b1;
    idle(20);
    checks++;
    if ({bus.Run, bus.ClearA_LoadB} !== 2'b00) begin
      errors++;
      $display("FAIL run_clear_release got %b%b exp 00", bus.Run, bus.ClearA_LoadB);
    end
  endtask

  task automatic test_switches();
    logic [SW_W-1:0] vals [2];
    logic [SW_W-1:0] prev;
    vals[0] = 8'hA5;
    vals[1] = 8'h5A;
    prev    = 8'h00;
    for (int v = 0; v < 2; v++) begin
      bus.SW_raw = vals[v];
      tick();
      checks++;
      if (bus.SW !== prev) begin
        errors++;
        $display("FAIL sw_lat1 got %h exp %h", bus.SW, prev);
      end
      tick();
      checks++;
      if (bus.SW !== vals[v]) begin
        errors++;
        $display("FAIL sw_lat2 got %h exp %h", bus.SW, vals[v]);
      end
      prev = vals[v];
    end
  endtask

  // Key pressed, reset after two counted mismatches, key held throughout.
  // First edge with Reset low is tick 1 afterwards; rise 5 edges later.
  task automatic test_reset_mid_debounce();
    bus.Run_n_raw = 1'b0;
    idle(4);
    checks++;
    if (bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got %b exp 0", bus.Run);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if ({bus.Run, bus.Run_pulse, bus.SW} !== {2'b00, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset got R=%b P=%b SW=%h exp 0 0 00", bus.Run, bus.Run_pulse, bus.SW);
    end
    Reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if ({bus.Run, bus.Run_pulse} !== {1'(i >= RISE), 1'(i == RISE)}) begin
        errors++;
        $display("FAIL mid_restart i=%0d got L=%b P=%b exp L=%b P=%b", i, bus.Run,
                 bus.Run_pulse, i >= RISE, i == RISE);
      end
    end
    bus.Run_n_raw = 1'b1;
    idle(8);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_both_keys();
    test_clear_during_run();
    test_switches();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
